// File: rtl/out_sram_pkg.sv
// Shared types for the output SRAM accumulate controller.
// Holds the FSM state and grant encodings and the default lane width.
package out_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_WB = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } gnt_t;

  localparam int LANE_W_DEF = 16;

endpackage

// File: rtl/out_acc_lane.sv
// One signed accumulation lane: stored partial sum plus incoming partial sum.
// Wraps modulo 2^LANE_W by default; saturates when ACC_SAT_EN is defined.
module out_acc_lane
  import out_sram_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] sum
);

`ifdef ACC_SAT_EN
  logic [LANE_W:0] ext;

  assign ext = {a[LANE_W-1], a} + {b[LANE_W-1], b};

  // Overflow shows up as the two top bits of the extended sum disagreeing.
  always_comb begin
    sum = ext[LANE_W-1:0];
    if (ext[LANE_W] != ext[LANE_W-1]) begin
      sum = ext[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/output_sram_acc_ctrl.sv
// Front-end for the single-port output SRAM: PE write / DMA read arbitration,
// per-lane read-modify-write accumulation and a bulk clear engine (ACC_SAT_EN selects saturating lanes).
module output_sram_acc_ctrl
  import out_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_acc,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a cycle where valid && ready; ready is only
  // raised for the port that wins arbitration in IDLE, so at most one transfers per cycle.

  localparam int NLANE = DATA_W / LANE_W;
  localparam bit FULL  = (DEPTH == (1 << ADDR_W));
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return !FULL && ({1'b0, a} >= (ADDR_W+1)'(DEPTH));
  endfunction

  state_t            state, state_nx;
  gnt_t              last_gnt;
  logic              gnt_rd, gnt_wr;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic [DATA_W-1:0] acc_sum;
  logic              acc_oor;
  logic              rd_pend;
  logic              rd_oor_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_now;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    out_acc_lane #(.LANE_W(LANE_W)) u_lane (
      .a   (sram_do[i*LANE_W +: LANE_W]),
      .b   (acc_data[i*LANE_W +: LANE_W]),
      .sum (acc_sum[i*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge CK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (clear_start)          state_nx = CLEAR;
        else if (gnt_wr && wr_acc) state_nx = ACC_WB;
      end
      ACC_WB:  state_nx = IDLE;
      CLEAR:   if (clr_cnt == LAST_ADDR) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_rd   = 1'b0;
    gnt_wr   = 1'b0;
    busy     = 1'b0;
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_di  = '0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (!clear_start) begin
            if (rd_valid && wr_valid) begin
              gnt_wr = (last_gnt == GNT_RD);
              gnt_rd = (last_gnt == GNT_WR);
            end else begin
              gnt_rd = rd_valid;
              gnt_wr = wr_valid;
            end
          end
          if (gnt_rd) begin
            sram_cs = !out_of_range(rd_addr);
            sram_oe = 1'b1;
            sram_a  = rd_addr;
          end else if (gnt_wr) begin
            sram_cs = !out_of_range(wr_addr);
            sram_a  = wr_addr;
            if (wr_acc) begin
              sram_oe = 1'b1;
            end else begin
              sram_web = 1'b0;
              sram_di  = wr_data;
            end
          end
        end
        ACC_WB: begin
          busy     = 1'b1;
          sram_cs  = !acc_oor;
          sram_web = 1'b0;
          sram_a   = acc_addr;
          sram_di  = acc_sum;
        end
        CLEAR: begin
          busy     = 1'b1;
          sram_cs  = 1'b1;
          sram_web = 1'b0;
          sram_a   = clr_cnt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      last_gnt <= GNT_RD;
      clr_cnt  <= '0;
      acc_addr <= '0;
      acc_data <= '0;
      acc_oor  <= 1'b0;
      rd_pend  <= 1'b0;
      rd_oor_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (gnt_rd)      last_gnt <= GNT_RD;
      else if (gnt_wr) last_gnt <= GNT_WR;
      clr_cnt <= (state == CLEAR) ? clr_cnt + ADDR_W'(1) : '0;
      if (gnt_wr && wr_acc) begin
        acc_addr <= wr_addr;
        acc_data <= wr_data;
        acc_oor  <= out_of_range(wr_addr);
      end
      rd_pend <= gnt_rd;
      if (gnt_rd)  rd_oor_q <= out_of_range(rd_addr);
      if (rd_pend) rdata_q  <= rdata_now;
    end
  end

  // The macro output is already a register; it is presented directly in the
  // valid cycle and held locally afterwards.
  assign rdata_now   = rd_oor_q ? '0 : sram_do;
  assign rdata_valid = rd_pend && !RST;
  assign rdata       = RST ? '0 : (rd_pend ? rdata_now : rdata_q);
  assign wr_ready    = gnt_wr;
  assign rd_ready    = gnt_rd;
  assign dbg_state   = state;

endmodule

// File: tb/tb_output_sram_acc_ctrl.sv
// Bench for output_sram_acc_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a word-level memory model.
module tb_output_sram_acc_ctrl;
  import out_sram_pkg::*;

  localparam int DW = 32;
  localparam int DEPTH = 512;
  localparam int AW = 9;
  localparam int LW = 16;
  localparam int NL = DW / LW;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic          wr_valid = 1'b0, rd_valid = 1'b0, wr_acc = 1'b0, clear_start = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_ready, rdata_valid, busy, sram_cs, sram_oe, sram_web;
  logic [DW-1:0] rdata, sram_di;
  logic [DW-1:0] sram_do = '0;
  logic [AW-1:0] sram_a;
  logic [1:0]    dbg_state;

  int n_chk = 0;
  int n_fail = 0;

  // clock / reset
  always #5 CK = ~CK;

  output_sram_acc_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LANE_W(LW)) dut (
    .CK(CK), .RST(RST),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_acc(wr_acc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rdata_valid(rdata_valid), .rdata(rdata), .clear_start(clear_start), .busy(busy),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do), .dbg_state(dbg_state)
  );

  // SRAM macro: write when web=0, registered read when oe with web=1
  logic [DW-1:0] sram_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram_mem[i] = $urandom;
  always @(posedge CK) begin
    if (sram_cs) begin
      if (!sram_web)    sram_mem[sram_a] = sram_di;
      else if (sram_oe) sram_do <= sram_mem[sram_a];
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      int s;
      s = int'($signed(a[i*LW +: LW])) + int'($signed(b[i*LW +: LW]));
`ifdef ACC_SAT_EN
      if (s > (2**(LW-1)) - 1) s = (2**(LW-1)) - 1;
      if (s < -(2**(LW-1)))    s = -(2**(LW-1));
`endif
      r[i*LW +: LW] = s[LW-1:0];
    end
    return r;
  endfunction

  // behavioural model: logical memory, busy window, last grant, pending read results
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            m_blk = 0;
  bit            m_last_wr = 1'b0;
  logic [DW-1:0] exp_q[$];
  bit            kn_q[$];
  logic [DW-1:0] m_held = '0;
  bit            m_held_kn = 1'b1;

  always @(negedge CK) begin
    bit ew, er;
    if (RST) begin
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_ready", rd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rdata_valid", rdata_valid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_sram_cs", sram_cs, 0);
      check("rst_sram_web", sram_web, 1);
      m_blk = 0;
      m_last_wr = 1'b0;
      exp_q.delete();
      kn_q.delete();
      m_held = '0;
      m_held_kn = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    end else begin
      ew = 1'b0;
      er = 1'b0;
      if (m_blk == 0 && !clear_start) begin
        if (wr_valid && rd_valid) begin
          if (m_last_wr) er = 1'b1;
          else           ew = 1'b1;
        end else begin
          ew = wr_valid;
          er = rd_valid;
        end
      end
      check("wr_ready", wr_ready, ew);
      check("rd_ready", rd_ready, er);
      check("busy", busy, m_blk > 0);
      if (exp_q.size() > 0) begin
        check("rdata_valid", rdata_valid, 1);
        if (kn_q[0]) check("rdata", rdata, exp_q[0]);
        m_held = exp_q.pop_front();
        m_held_kn = kn_q.pop_front();
      end else begin
        check("rdata_valid_idle", rdata_valid, 0);
        if (m_held_kn) check("rdata_hold", rdata, m_held);
      end
      if (m_blk > 0) begin
        m_blk--;
      end else if (clear_start) begin
        m_blk = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[i] = '0;
          m_known[i] = 1'b1;
        end
      end else if (ew) begin
        m_last_wr = 1'b1;
        if (wr_acc) begin
          m_mem[wr_addr] = lane_add(m_mem[wr_addr], wr_data);
          m_blk = 1;
        end else begin
          m_mem[wr_addr] = wr_data;
          m_known[wr_addr] = 1'b1;
        end
      end else if (er) begin
        m_last_wr = 1'b0;
        exp_q.push_back(m_mem[rd_addr]);
        kn_q.push_back(m_known[rd_addr]);
      end
    end
  end

  // driver tasks
  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic acc);
    int n = 0;
    @(posedge CK); #1;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_acc = acc;
    @(negedge CK);
    while (!wr_ready && n < 2000) begin n++; @(negedge CK); end
    check("wr_accept", wr_ready, 1);
    @(posedge CK); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    int n = 0;
    @(posedge CK); #1;
    rd_valid = 1'b1; rd_addr = a;
    @(negedge CK);
    while (!rd_ready && n < 2000) begin n++; @(negedge CK); end
    check("rd_accept", rd_ready, 1);
    @(posedge CK); #1;
    rd_valid = 1'b0;
    @(negedge CK);
    check("rd_pulse_next_cycle", rdata_valid, 1);
    d = rdata;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 99) < 80) return AW'($urandom_range(0, 15));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int            g;
    int            exp_arb [4];
    int            n;
    bit            wa, ra;

    exp_arb = '{1, 2, 1, 2};
    repeat (3) @(posedge CK);
    #1 RST = 1'b0;

    // arbitration straight out of reset: write first, then alternate
    @(posedge CK); #1;
    wr_valid = 1'b1; wr_addr = 9'd20; wr_data = 32'h1234_5678; wr_acc = 1'b0;
    rd_valid = 1'b1; rd_addr = 9'd21;
    for (int i = 0; i < 4; i++) begin
      @(negedge CK);
      g = wr_ready ? 1 : (rd_ready ? 2 : 0);
      check("arb_grant", g, exp_arb[i]);
      @(posedge CK); #1;
    end
    wr_valid = 1'b0; rd_valid = 1'b0;

    // overwrite then read
    do_wr(9'd5, 32'h0001_0002, 1'b0);
    do_rd(9'd5, d);
    check("ovw_read5", d, 32'h0001_0002);

    // accumulate: lane0 wraps, no carry into lane1
    do_wr(9'd7, 32'h0003_FFFF, 1'b0);
    do_wr(9'd7, 32'h0002_0001, 1'b1);
    @(negedge CK);
    check("acc_busy", busy, 1);
    check("acc_state", dbg_state, ACC_WB);
    do_rd(9'd7, d);
    check("acc_read7", d, 32'h0005_0000);

    // saturating vs wrapping lanes
    do_wr(9'd9, 32'h7FFF_8000, 1'b0);
    do_wr(9'd9, 32'h0001_FFFF, 1'b1);
    do_rd(9'd9, d);
`ifdef ACC_SAT_EN
    check("sat_read9", d, 32'h7FFF_8000);
`else
    check("wrap_read9", d, 32'h8000_7FFF);
`endif

    // clear: busy for exactly DEPTH cycles, then zeros everywhere
    @(posedge CK); #1 clear_start = 1'b1;
    @(posedge CK); #1 clear_start = 1'b0;
    n = 0;
    do begin
      @(negedge CK);
      if (busy) n++;
    end while (busy && n < 2000);
    check("clear_busy_cycles", n, DEPTH);
    do_rd(9'd0, d);   check("clr_read0", d, 0);
    do_rd(9'd255, d); check("clr_read255", d, 0);
    do_rd(9'd511, d); check("clr_read511", d, 0);
    do_rd(9'd5, d);   check("clr_read5", d, 0);

    // randomized traffic; requests are held until accepted
    repeat (3000) begin
      @(negedge CK);
      wa = wr_valid && wr_ready;
      ra = rd_valid && rd_ready;
      @(posedge CK); #1;
      if (!wr_valid || wa) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_addr  = rand_addr();
        wr_data  = $urandom;
        wr_acc   = 1'($urandom_range(0, 1));
      end
      if (!rd_valid || ra) begin
        rd_valid = 1'($urandom_range(0, 1));
        rd_addr  = rand_addr();
      end
      clear_start = ($urandom_range(0, 499) == 0);
    end
    @(posedge CK); #1;
    wr_valid = 1'b0; rd_valid = 1'b0; clear_start = 1'b0;
    repeat (600) @(posedge CK);

    // reset while clearing, at clr_cnt == 100
    #1 clear_start = 1'b1;
    @(posedge CK); #1 clear_start = 1'b0;
    repeat (99) @(posedge CK);
    @(negedge CK);
    check("midclr_busy", busy, 1);
    check("midclr_state", dbg_state, CLEAR);
    @(posedge CK); #1 RST = 1'b1;
    @(posedge CK); #1 RST = 1'b0;
    @(negedge CK);
    check("post_rst_busy", busy, 0);
    check("post_rst_state", dbg_state, IDLE);
    check("post_rst_sram_cs", sram_cs, 0);
    check("post_rst_sram_oe", sram_oe, 0);
    check("post_rst_sram_web", sram_web, 1);
    check("post_rst_sram_a", sram_a, 0);
    check("post_rst_sram_di", sram_di, 0);
    check("post_rst_rdata", rdata, 0);

    do_wr(9'd3, 32'h0010_0020, 1'b0);
    do_wr(9'd3, 32'h0001_0001, 1'b1);
    do_rd(9'd3, d);
    check("post_rst_acc_read3", d, 32'h0011_0021);

    repeat (3) @(posedge CK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
